// File: rtl/rggen_apb_arbiter.sv
// Round-robin arbiter sharing one APB slave port among REQUESTERS request/ready masters.
// Latency: 2 cycles from request to ready (IDLE, SETUP, ACCESS+pready); 3 cycles per transfer back to back.
// Backpressure: a requester holds i_req_valid until its o_req_ready pulse; pready low stretches ACCESS.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req_valid/write/address/     per-requester command, latched when the requester is granted
//   wdata/strobe
//   o_req_ready                    one-cycle completion pulse for the owner
//   o_req_rdata, o_req_error       response, valid only together with o_req_ready
//   o_psel .. o_pprot, i_pready,   APB master side towards the register block
//   i_prdata, i_pslverr
//   o_grant                        one-hot owner of the transfer in flight, 0 when idle
//
// Optional: define RGGEN_APB_ARBITER_TIMEOUT_EN to terminate an ACCESS phase with an
// error after TIMEOUT_CYCLES cycles without pready. Without it ACCESS waits forever.
module rggen_apb_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic [REQUESTERS-1:0]                      i_req_valid,
  input  logic [REQUESTERS-1:0]                      i_req_write,
  input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [REQUESTERS-1:0][BUS_WIDTH-1:0]       i_req_wdata,
  input  logic [REQUESTERS-1:0][BUS_WIDTH/8-1:0]     i_req_strobe,
  output logic [REQUESTERS-1:0]                      o_req_ready,
  output logic [BUS_WIDTH-1:0]                       o_req_rdata,
  output logic                                       o_req_error,
  output logic                                       o_psel,
  output logic                                       o_penable,
  output logic                                       o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]                   o_paddr,
  output logic [BUS_WIDTH-1:0]                       o_pwdata,
  output logic [BUS_WIDTH/8-1:0]                     o_pstrb,
  output logic [2:0]                                 o_pprot,
  input  logic                                       i_pready,
  input  logic [BUS_WIDTH-1:0]                       i_prdata,
  input  logic                                       i_pslverr,
  output logic [REQUESTERS-1:0]                      o_grant
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [PTR_W:0]   LP_N    = (PTR_W + 1)'(REQUESTERS);
  localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [PTR_W-1:0]         r_ptr;
  logic [PTR_W-1:0]         r_owner;
  logic [REQUESTERS-1:0]    r_grant;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic [BUS_WIDTH/8-1:0]   r_strb;

  logic [2*REQUESTERS-1:0]  w_valid_dbl;
  logic [REQUESTERS-1:0]    w_valid_rot;
  logic [PTR_W-1:0]         w_offset;
  logic [PTR_W:0]           w_winner_sum;
  logic [PTR_W-1:0]         w_winner;
  logic [PTR_W-1:0]         w_ptr_next;
  logic                     w_any_valid;
  logic                     w_timeout;
  logic                     w_complete;
  logic                     w_ready_fire;

  // Rotate the request vector so bit 0 is the requester the pointer names;
  // the lowest set bit of the rotated vector is the distance to the winner.
  assign w_valid_dbl = {i_req_valid, i_req_valid};
  assign w_valid_rot = REQUESTERS'(w_valid_dbl >> r_ptr);
  assign w_any_valid = |i_req_valid;

  always_comb begin
    w_offset = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (w_valid_rot[i]) begin
        w_offset = PTR_W'(i);
      end
    end
  end

  // pointer + offset, wrapped modulo REQUESTERS (not necessarily a power of two)
  assign w_winner_sum = {1'b0, r_ptr} + {1'b0, w_offset};
  assign w_winner     = (w_winner_sum >= LP_N) ? PTR_W'(w_winner_sum - LP_N)
                                               : PTR_W'(w_winner_sum);
  assign w_ptr_next   = (r_owner == LP_LAST) ? '0 : r_owner + PTR_W'(1);

`ifdef RGGEN_APB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_to_cnt;

  // Counts ACCESS cycles without pready; the cycle that finds it at
  // TIMEOUT_CYCLES-1 is the last ACCESS cycle allowed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == ACCESS) && !i_pready) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ACCESS) && !i_pready && (r_to_cnt == LP_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // pready wins over a timeout in the same cycle
  assign w_complete = (r_state == ACCESS) && (i_pready || w_timeout);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_valid) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_complete) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Command is captured once at grant; later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if ((r_state == IDLE) && w_any_valid) begin
      r_owner <= w_winner;
      r_grant <= {{(REQUESTERS-1){1'b0}}, 1'b1} << w_winner;
      r_write <= i_req_write[w_winner];
      r_addr  <= i_req_address[w_winner];
      r_wdata <= i_req_wdata[w_winner];
      r_strb  <= i_req_strobe[w_winner];
    end else if (w_complete) begin
      r_grant <= '0;
      r_ptr   <= w_ptr_next;
    end
  end

  // A transfer cut short by reset must not report completion.
  assign w_ready_fire = w_complete && i_rst_n;

  assign o_req_ready = w_ready_fire ? r_grant : '0;
  assign o_req_rdata = (w_ready_fire && i_pready) ? i_prdata : '0;
  assign o_req_error = w_ready_fire && (i_pready ? i_pslverr : 1'b1);

  assign o_psel    = (r_state != IDLE);
  assign o_penable = (r_state == ACCESS);
  assign o_pwrite  = r_write;
  assign o_paddr   = r_addr;
  assign o_pwdata  = r_wdata;
  assign o_pstrb   = r_strb;
  assign o_pprot   = 3'b000;
  assign o_grant   = r_grant;

endmodule
